nvdla_cmac_core_wt_bank_ctrl: RTL and testbench
===============================================

# nvdla_cmac_core_wt_bank_ctrl

- Sequences the CMAC weight double-buffer (shadow/active banks) behind the CMAC input retiming stage.
- Steers each incoming weight write into the shadow bank.
- Swaps banks on the stripe-start data beat and qualifies data beats for the MAC cells.
- Flags protocol errors (missing stripe boundaries, incompletely loaded weights) as sticky status.

## Interface
Parameters:
- ATOMK_HALF, 8, number of MAC cells / width of weight select
- CNT_W, 16, width of stripe statistics counters

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- in_dat_pvld  in  1  retimed data beat valid
- in_dat_stripe_st  in  1  beat is first of stripe (qualified by in_dat_pvld)
- in_dat_stripe_end  in  1  beat is last of stripe (qualified by in_dat_pvld)
- in_wt_pvld  in  1  retimed weight beat valid
- in_wt_sel  in  ATOMK_HALF  one-hot-or-multi target cells of weight beat
- cfg_cell_mask  in  ATOMK_HALF  cells that must hold weights for a stripe (quasi-static)
- err_clr  in  1  pulse, clears sticky errors
- wt_wr_en  out  ATOMK_HALF  per-cell shadow write enable (combinational)
- wt_wr_bank  out  1  bank index written (= ~active_bank, combinational)
- mac_dat_vld  out  1  accepted data beat, one cycle delayed
- mac_dat_bank  out  1  weight bank the delayed beat must use
- mac_stripe_end  out  1  delayed stripe_end of accepted beat
- err_protocol  out  1  sticky boundary violation
- err_wt_underrun  out  1  sticky: swap with required cells unloaded
- stripe_cnt  out  CNT_W  completed stripes
- last_stripe_len  out  CNT_W  beats in last completed stripe

## Operation
- Registers: active_bank (1b), shadow_vld[ATOMK_HALF], FSM, atom_cnt, stat counters, sticky errors.
- wt_wr_en = in_wt_pvld ? in_wt_sel : 0. Every write sets the corresponding shadow_vld bits.
- Swap event = in_dat_pvld & in_dat_stripe_st.
  - active_bank toggles and shadow_vld clears to 0.
  - A weight write in the swap cycle lands in the outgoing shadow (the bank being activated). It counts toward that stripe's completeness check and does not set the new shadow_vld.
- Underrun check at swap: if ((shadow_vld | wt_wr_en) & cfg_cell_mask) != cfg_cell_mask, set err_wt_underrun. The swap still happens.
- FSM states: IDLE (reset), RUN (inside stripe), GAP (between stripes).
  - IDLE/GAP + swap without end -> RUN.
  - IDLE/GAP + swap with stripe_end (single-beat stripe) -> GAP.
  - IDLE/GAP + pvld without stripe_st: set err_protocol, beat dropped (not accepted), state unchanged.
  - RUN + stripe_end without stripe_st -> GAP.
  - RUN + stripe_st: set err_protocol, swap still performed, beat accepted. Next state is RUN, or GAP if stripe_end is also set.
- A beat is accepted unless it was dropped.
- atom_cnt: loads 1 on an accepted stripe_st beat and increments (saturating at all-ones) on other accepted beats. On an accepted stripe_end beat, last_stripe_len <= final count and stripe_cnt increments (wraps).
- err_clr clears both sticky errors. An error setting in the same cycle wins.

## Timing
- Reset values: active_bank 0, shadow_vld 0, FSM IDLE, mac_dat_vld 0, mac_dat_bank 0, mac_stripe_end 0, errors 0, counters 0. wt_wr_bank is 1 after reset.
- wt_wr_en / wt_wr_bank: 0-cycle combinational from inputs and state.
- mac_dat_vld/mac_dat_bank/mac_stripe_end: 1-cycle latency. mac_dat_bank carries the post-swap bank for a stripe_st beat.
- Errors and statistics are visible the cycle after the triggering beat.
- Reset asserted mid-stripe aborts immediately: banks return to 0, and the first beat after reset must be stripe_st, otherwise err_protocol.
- No backpressure: one data and one weight beat may be presented every cycle.

## Configuration
- NVDLA_CMAC_WT_BANK_STAT_EN defined: atom_cnt, stripe_cnt and last_stripe_len are implemented as above.
- Not defined: these counters are not built, and stripe_cnt and last_stripe_len are tied to 0.
- The FSM, bank control and error flags are identical in both builds.

## Test plan
- cfg_cell_mask=0xFF; write sel 0x0F then 0xF0; then stripe_st beat, 3 beats, stripe_end beat -> mac_dat_bank=1 on all 5 beats, err_wt_underrun=0, last_stripe_len=5, stripe_cnt=1.
- cfg_cell_mask=0xFF, only sel 0x7F written, then stripe_st -> err_wt_underrun=1 next cycle; err_clr -> 0.
- sel 0x80 written in the same cycle as stripe_st after 0x7F earlier -> no underrun; next-cycle wt_wr_bank=0, shadow_vld=0.
- From reset, data beat without stripe_st -> mac_dat_vld stays 0, err_protocol=1, FSM IDLE.
- Single-beat stripe (st and end together) twice back-to-back -> mac_dat_bank 1 then 0, stripe_cnt=2, last_stripe_len=1.
- Assert nvdla_core_rstn low mid-stripe -> all outputs at reset values asynchronously; next stripe starts on bank 1.

Source files
------------

// File: rtl/nvdla_cmac_core_wt_bank_ctrl.sv
// nvdla_cmac_core_wt_bank_ctrl: sequences CMAC weight shadow/active banks, qualifies data beats, flags protocol errors.
// Ports: nvdla_core_clk/nvdla_core_rstn (async active-low); in_dat_* retimed data beat; in_wt_pvld/in_wt_sel weight beat;
// cfg_cell_mask required cells; err_clr clears sticky errors; wt_wr_en/wt_wr_bank shadow write steering (comb);
// mac_dat_vld/mac_dat_bank/mac_stripe_end delayed accepted beat; err_protocol/err_wt_underrun sticky status;
// stripe_cnt/last_stripe_len statistics, built only when NVDLA_CMAC_WT_BANK_STAT_EN is defined (else tied 0).
module nvdla_cmac_core_wt_bank_ctrl #(
  parameter int ATOMK_HALF = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  in_dat_pvld,
  input  logic                  in_dat_stripe_st,
  input  logic                  in_dat_stripe_end,
  input  logic                  in_wt_pvld,
  input  logic [ATOMK_HALF-1:0] in_wt_sel,
  input  logic [ATOMK_HALF-1:0] cfg_cell_mask,
  input  logic                  err_clr,
  output logic [ATOMK_HALF-1:0] wt_wr_en,
  output logic                  wt_wr_bank,
  output logic                  mac_dat_vld,
  output logic                  mac_dat_bank,
  output logic                  mac_stripe_end,
  output logic                  err_protocol,
  output logic                  err_wt_underrun,
  output logic [CNT_W-1:0]      stripe_cnt,
  output logic [CNT_W-1:0]      last_stripe_len
);
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  state_t state_q, state_d;
  logic active_bank_q, active_bank_d;
  logic [ATOMK_HALF-1:0] shadow_vld_q, shadow_vld_d;
  logic mac_dat_vld_q, mac_dat_bank_q, mac_stripe_end_q;
  logic err_protocol_q, err_protocol_d, err_wt_underrun_q, err_wt_underrun_d;
  logic swap, drop, accept, proto_set, underrun;
  assign swap       = in_dat_pvld & in_dat_stripe_st;
  assign wt_wr_en   = in_wt_pvld ? in_wt_sel : '0;
  assign wt_wr_bank = ~active_bank_q;
  // a write in the swap cycle lands in the bank being activated, so it counts toward completeness
  assign underrun   = swap & (((shadow_vld_q | wt_wr_en) & cfg_cell_mask) != cfg_cell_mask);
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = swap ? (in_dat_stripe_end ? GAP : RUN) :
              (state_q == RUN && in_dat_pvld && in_dat_stripe_end) ? GAP : state_q;
  always_comb begin
    drop      = in_dat_pvld & ~in_dat_stripe_st & (state_q != RUN);
    accept    = in_dat_pvld & ~drop;
    proto_set = drop | (swap & (state_q == RUN));
  end
  always_comb begin
    active_bank_d     = active_bank_q ^ swap;
    shadow_vld_d      = swap ? '0 : (shadow_vld_q | wt_wr_en);
    err_protocol_d    = proto_set | (err_protocol_q & ~err_clr);
    err_wt_underrun_d = underrun | (err_wt_underrun_q & ~err_clr);
  end
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      active_bank_q     <= 1'b0;
      shadow_vld_q      <= '0;
      mac_dat_vld_q     <= 1'b0;
      mac_dat_bank_q    <= 1'b0;
      mac_stripe_end_q  <= 1'b0;
      err_protocol_q    <= 1'b0;
      err_wt_underrun_q <= 1'b0;
    end else begin
      active_bank_q     <= active_bank_d;
      shadow_vld_q      <= shadow_vld_d;
      mac_dat_vld_q     <= accept;
      mac_dat_bank_q    <= accept ? active_bank_d : mac_dat_bank_q;
      mac_stripe_end_q  <= accept & in_dat_stripe_end;
      err_protocol_q    <= err_protocol_d;
      err_wt_underrun_q <= err_wt_underrun_d;
    end
  assign mac_dat_vld     = mac_dat_vld_q;
  assign mac_dat_bank    = mac_dat_bank_q;
  assign mac_stripe_end  = mac_stripe_end_q;
  assign err_protocol    = err_protocol_q;
  assign err_wt_underrun = err_wt_underrun_q;
`ifdef NVDLA_CMAC_WT_BANK_STAT_EN
  logic [CNT_W-1:0] atom_cnt_q, atom_cnt_d, stripe_cnt_q, last_stripe_len_q;
  always_comb
    atom_cnt_d = !accept ? atom_cnt_q :
                 in_dat_stripe_st ? CNT_W'(1) :
                 (&atom_cnt_q) ? atom_cnt_q : atom_cnt_q + 1'b1;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      atom_cnt_q        <= '0;
      stripe_cnt_q      <= '0;
      last_stripe_len_q <= '0;
    end else begin
      atom_cnt_q        <= atom_cnt_d;
      stripe_cnt_q      <= (accept & in_dat_stripe_end) ? stripe_cnt_q + 1'b1 : stripe_cnt_q;
      last_stripe_len_q <= (accept & in_dat_stripe_end) ? atom_cnt_d : last_stripe_len_q;
    end
  assign stripe_cnt      = stripe_cnt_q;
  assign last_stripe_len = last_stripe_len_q;
`else
  assign stripe_cnt      = '0;
  assign last_stripe_len = '0;
`endif
endmodule

// File: tb/tb_nvdla_cmac_core_wt_bank_ctrl.sv
// tb_nvdla_cmac_core_wt_bank_ctrl: vector table, corner sequences and randomized run against a reference model.
module tb_nvdla_cmac_core_wt_bank_ctrl;
  logic clk = 1'b0, rstn = 1'b0;
  logic pvld = 0, st = 0, en = 0, wp = 0, clr = 0;
  logic [7:0] sel = 0, mask = 0;
  logic [7:0] wt_wr_en;
  logic wt_wr_bank, mac_dat_vld, mac_dat_bank, mac_stripe_end, err_protocol, err_wt_underrun;
  logic [15:0] stripe_cnt, last_stripe_len;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  nvdla_cmac_core_wt_bank_ctrl #(.ATOMK_HALF(8), .CNT_W(16)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_dat_pvld(pvld), .in_dat_stripe_st(st), .in_dat_stripe_end(en),
    .in_wt_pvld(wp), .in_wt_sel(sel), .cfg_cell_mask(mask), .err_clr(clr),
    .wt_wr_en(wt_wr_en), .wt_wr_bank(wt_wr_bank),
    .mac_dat_vld(mac_dat_vld), .mac_dat_bank(mac_dat_bank), .mac_stripe_end(mac_stripe_end),
    .err_protocol(err_protocol), .err_wt_underrun(err_wt_underrun),
    .stripe_cnt(stripe_cnt), .last_stripe_len(last_stripe_len));
  // reference model: bank in use, set of cells loaded, whether a stripe is open
  bit m_bank, m_in, m_prot, m_und, m_vld, m_mbank, m_mend;
  bit [7:0] m_loaded;
  int m_len;
  bit [15:0] m_last, m_cnt;
  function automatic void model_reset();
    m_bank = 0; m_in = 0; m_prot = 0; m_und = 0; m_vld = 0; m_mbank = 0; m_mend = 0;
    m_loaded = 0; m_len = 0; m_last = 0; m_cnt = 0;
  endfunction
  function automatic void model_step(bit p, bit s, bit e, bit w, bit [7:0] sl, bit [7:0] mk, bit c);
    bit [7:0] wr = w ? sl : 8'h0;
    bit sw = p && s;
    bit acc = p && (s || m_in);
    bit pset = (p && !s && !m_in) || (sw && m_in);
    bit uset = sw && (((m_loaded | wr) & mk) != mk);
    m_prot = pset ? 1'b1 : (c ? 1'b0 : m_prot);
    m_und = uset ? 1'b1 : (c ? 1'b0 : m_und);
    if (sw) begin m_bank = !m_bank; m_loaded = 0; end
    else m_loaded = m_loaded | wr;
    m_vld = acc;
    m_mend = acc && e;
    if (acc) begin
      m_mbank = m_bank;
      m_len = s ? 1 : (m_len < 65535 ? m_len + 1 : 65535);
      if (e) begin m_last = 16'(m_len); m_cnt = m_cnt + 16'd1; end
    end
    if (p) m_in = s ? !e : (m_in && !e);
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk_stats(input int exp_cnt, input int exp_last);
`ifdef NVDLA_CMAC_WT_BANK_STAT_EN
    chk("stripe_cnt", 32'(stripe_cnt), 32'(exp_cnt));
    chk("last_stripe_len", 32'(last_stripe_len), 32'(exp_last));
`else
    chk("stripe_cnt", 32'(stripe_cnt), 32'(exp_cnt * 0));
    chk("last_stripe_len", 32'(last_stripe_len), 32'(exp_last * 0));
`endif
  endtask
  task automatic cycle(input bit p, s, e, w, input bit [7:0] sl, mk, input bit c);
    pvld = p; st = s; en = e; wp = w; sel = sl; mask = mk; clr = c;
    #1;
    chk("wt_wr_en", 32'(wt_wr_en), 32'(w ? sl : 8'h0));
    chk("wt_wr_bank", 32'(wt_wr_bank), 32'(!m_bank));
    @(posedge clk);
    model_step(p, s, e, w, sl, mk, c);
    #1;
    chk("model_vld", 32'(mac_dat_vld), 32'(m_vld));
    if (m_vld) begin
      chk("model_bank", 32'(mac_dat_bank), 32'(m_mbank));
      chk("model_end", 32'(mac_stripe_end), 32'(m_mend));
    end
    chk("model_prot", 32'(err_protocol), 32'(m_prot));
    chk("model_und", 32'(err_wt_underrun), 32'(m_und));
    chk_stats(int'(m_cnt), int'(m_last));
  endtask
  task automatic chk_reset_vals();
    chk("rst_vld", 32'(mac_dat_vld), 0);
    chk("rst_bank", 32'(mac_dat_bank), 0);
    chk("rst_end", 32'(mac_stripe_end), 0);
    chk("rst_prot", 32'(err_protocol), 0);
    chk("rst_und", 32'(err_wt_underrun), 0);
    chk("rst_wt_wr_bank", 32'(wt_wr_bank), 1);
    chk("rst_stripe_cnt", 32'(stripe_cnt), 0);
    chk("rst_last_len", 32'(last_stripe_len), 0);
  endtask
  task automatic apply_reset();
    pvld = 0; st = 0; en = 0; wp = 0; sel = 0; mask = 0; clr = 0;
    @(posedge clk);
    #2 rstn = 1'b0;
    model_reset();
    #1 chk_reset_vals();
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask
  typedef struct {
    bit p, s, e, w;
    bit [7:0] sl, mk;
    bit c;
    bit vld, mbank, mend, prot, und, wbank;
  } vec_t;
  function automatic vec_t mkv(bit p, s, e, w, bit [7:0] sl, mk, bit c, bit vld, mbank, mend, prot, und, wbank);
    vec_t v;
    v.p = p; v.s = s; v.e = e; v.w = w; v.sl = sl; v.mk = mk; v.c = c;
    v.vld = vld; v.mbank = mbank; v.mend = mend; v.prot = prot; v.und = und; v.wbank = wbank;
    return v;
  endfunction
  vec_t tbl[14];
  initial begin
    tbl[0]  = mkv(0,0,0,1,8'h0F,8'hFF,0, 0,0,0,0,0,1);
    tbl[1]  = mkv(0,0,0,1,8'hF0,8'hFF,0, 0,0,0,0,0,1);
    tbl[2]  = mkv(1,1,0,0,8'h00,8'hFF,0, 1,1,0,0,0,1);
    tbl[3]  = mkv(1,0,0,0,8'h00,8'hFF,0, 1,1,0,0,0,0);
    tbl[4]  = mkv(1,0,0,0,8'h00,8'hFF,0, 1,1,0,0,0,0);
    tbl[5]  = mkv(1,0,0,0,8'h00,8'hFF,0, 1,1,0,0,0,0);
    tbl[6]  = mkv(1,0,1,0,8'h00,8'hFF,0, 1,1,1,0,0,0);
    tbl[7]  = mkv(0,0,0,1,8'h7F,8'hFF,0, 0,0,0,0,0,0);
    tbl[8]  = mkv(1,1,0,0,8'h00,8'hFF,0, 1,0,0,0,1,0);
    tbl[9]  = mkv(1,0,1,0,8'h00,8'hFF,1, 1,0,1,0,0,1);
    tbl[10] = mkv(0,0,0,1,8'h7F,8'hFF,0, 0,0,0,0,0,1);
    tbl[11] = mkv(1,1,1,1,8'h80,8'hFF,0, 1,1,1,0,0,1);
    tbl[12] = mkv(1,1,1,0,8'h00,8'h00,0, 1,0,1,0,0,0);
    tbl[13] = mkv(1,1,1,0,8'h00,8'h00,0, 1,1,1,0,0,1);
    model_reset();
    #3 chk_reset_vals();
    @(posedge clk);
    #1 rstn = 1'b1;
    cycle(1,0,0,0,8'h00,8'hFF,0);
    chk("idle_drop_vld", 32'(mac_dat_vld), 0);
    chk("idle_drop_prot", 32'(err_protocol), 1);
    cycle(1,0,1,0,8'h00,8'hFF,0);
    chk("idle_stay_vld", 32'(mac_dat_vld), 0);
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      pvld = tbl[i].p; st = tbl[i].s; en = tbl[i].e; wp = tbl[i].w;
      sel = tbl[i].sl; mask = tbl[i].mk; clr = tbl[i].c;
      #1 chk($sformatf("tbl%0d_wbank", i), 32'(wt_wr_bank), 32'(tbl[i].wbank));
      cycle(tbl[i].p, tbl[i].s, tbl[i].e, tbl[i].w, tbl[i].sl, tbl[i].mk, tbl[i].c);
      chk($sformatf("tbl%0d_vld", i), 32'(mac_dat_vld), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_bank", i), 32'(mac_dat_bank), 32'(tbl[i].mbank));
        chk($sformatf("tbl%0d_end", i), 32'(mac_stripe_end), 32'(tbl[i].mend));
      end
      chk($sformatf("tbl%0d_prot", i), 32'(err_protocol), 32'(tbl[i].prot));
      chk($sformatf("tbl%0d_und", i), 32'(err_wt_underrun), 32'(tbl[i].und));
      if (i == 6) chk_stats(1, 5);
      if (i == 11) chk("swap_wt_wr_bank", 32'(wt_wr_bank), 0);
    end
    chk_stats(5, 1);
    cycle(1,1,1,0,8'h00,8'h00,0);
    cycle(1,1,0,0,8'h00,8'h00,0);
    cycle(1,0,0,0,8'h00,8'h00,0);
    chk("pre_rst_bank", 32'(mac_dat_bank), 1);
    #2 rstn = 1'b0;
    model_reset();
    #1 chk_reset_vals();
    @(posedge clk);
    #1 rstn = 1'b1;
    cycle(1,1,0,0,8'h00,8'h00,0);
    chk("post_rst_bank", 32'(mac_dat_bank), 1);
    chk("post_rst_vld", 32'(mac_dat_vld), 1);
    for (int i = 0; i < 3000; i++) begin
      bit [7:0] rs = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom);
      bit [7:0] rm = ($urandom_range(3) == 0) ? 8'($urandom) : (($urandom_range(1) == 0) ? 8'h0F : 8'hFF);
      cycle($urandom_range(1) == 1, $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(4) > 1, rs, rm, $urandom_range(7) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
